rsa_load_ctrl: RTL and testbench
================================

# rsa_load_ctrl

Byte-stream front-end controller for the RSA datapath. It accepts the UART receive byte stream and assembles three N-bit operands in order: message M, exponent E, modulus N. It then issues a single-cycle start to the modular-exponentiation core, waits for completion, and returns the N-bit result to the UART transmitter MSB byte first. It sits between the UART rx/tx pair and the modexp core and owns all frame sequencing.

## Interface
- `N`, 16: operand width in bits; multiple of 8, ≥ 16.
- `TIMEOUT_CYCLES`, 1000000: inter-byte timeout in clk cycles; used only when the timeout feature is compiled in.

- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  `rx_byte` valid this cycle; one byte per high cycle.
- `rx_byte`  in  8  received byte.
- `op_m`, `op_e`, `op_n`  out  N each  assembled operands; stable outside their own load phase.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_done`  in  1  core completion; `core_result` valid while high.
- `core_result`  in  N  exponentiation result.
- `tx_valid`  out  1  `tx_byte` offered to the transmitter.
- `tx_byte`  out  8  result byte.
- `tx_ready`  in  1  transmitter accepts when `tx_valid & tx_ready`.
- `busy`  out  1  high in START, WAIT and SEND.
- `overrun`  out  1  sticky; an rx byte arrived while `busy`.
- `timeout`  out  1  one-cycle pulse on frame abort.

## Operation
- States: LOAD_M, LOAD_E, LOAD_N, START, WAIT, SEND. Reset state is LOAD_M.
- Byte counter width is clog2(N/8)+1. It is cleared on every state change.
- In any LOAD_x state, `rx_valid` high: `op_x <= {op_x[N-9:0], rx_byte}` and the counter increments. The first byte ends in the MSB.
  - On the N/8-th byte: LOAD_M→LOAD_E, LOAD_E→LOAD_N, LOAD_N→START.
- START: `core_start`=1 for exactly this one cycle, then → WAIT.
- WAIT: on `core_done`=1, capture `core_result` into an internal N-bit tx shift register and → SEND.
- SEND: `tx_valid`=1 and `tx_byte` = shift register [N-1:N-8].
  - On `tx_valid & tx_ready`: shift left 8 and increment the counter.
  - After the N/8-th transfer: → LOAD_M and `tx_valid` drops the next cycle.
- rx byte while `busy`: byte is dropped, operands are unchanged, and `overrun` is set. It is cleared only by reset.
- `core_done` outside WAIT is ignored.
- Reset values: all operands 0, tx shift register 0, counters 0, and `core_start`, `tx_valid`, `busy`, `overrun`, `timeout` all 0.
- Reset asserted mid-frame aborts immediately. After release the block starts at LOAD_M.

## Timing
- Last byte of N accepted on edge k → `core_start` high during cycle k+1 → WAIT from k+2.
- `core_done` sampled on edge j → `tx_valid` high from cycle j+1 with the first byte.
- Throughput is one byte per cycle in both directions when rx is back-to-back and `tx_ready` is held high.
- `tx_byte` holds stable while `tx_valid` is high and `tx_ready` is low.
- `busy` is registered and changes on the same edge as the state.

## Configuration
- `RSA_LOAD_TIMEOUT_EN` defined: a timeout counter runs in LOAD_x states whenever a frame is partially received, i.e. state ≠ LOAD_M or counter ≠ 0.
  - The counter clears on every accepted byte.
  - On reaching `TIMEOUT_CYCLES`: state → LOAD_M, byte counter → 0, `timeout` pulses for 1 cycle. Operand registers keep their partial contents.
- `RSA_LOAD_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied 0, and a partial frame waits indefinitely.

## Structure
- Package `rsa_ctrl_pkg`: state enum `load_state_t`, the bytes-per-operand helper function, and the default `TIMEOUT_CYCLES`.
- One sub-module, `byte_shift_reg`: an N-bit register with load, shift-in-byte, shift-out-byte and MSB-byte output. It is used for the tx path and for each operand, with shift-in enabled per state.

## Test plan
- N=16, rx 0x12,0x34,0x56,0x78,0x9A,0xBC back-to-back → op_m=0x1234, op_e=0x5678, op_n=0x9ABC; `core_start` high exactly one cycle, the cycle after 0xBC.
- In WAIT, `core_done`=1 with `core_result`=0xBEEF, `tx_ready`=1 → tx bytes 0xBE then 0xEF on consecutive cycles; then state LOAD_M, `busy`=0.
- `tx_ready` held low 5 cycles during SEND → `tx_valid`=1 and `tx_byte`=0xBE stable throughout; release → 0xBE then 0xEF.
- rx byte 0x55 during WAIT → `overrun`=1, operands unchanged; next frame loads normally and `overrun` stays 1.
- Assert `rst_n` low after 3 bytes → all outputs 0 asynchronously; after release, bytes 0xAA,0xBB → op_m=0xAABB.
- With `RSA_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: one byte then 8 idle cycles → `timeout` one-cycle pulse, state LOAD_M; next two bytes land in op_m.

Source files
------------

// File: rtl/rsa_ctrl_pkg.sv
// Shared types and helpers for the RSA byte-stream load controller.
package rsa_ctrl_pkg;

   typedef enum logic [2:0] {
      LOAD_M,
      LOAD_E,
      LOAD_N,
      START,
      WAIT,
      SEND
   } load_state_t;

   localparam int DEF_TIMEOUT_CYCLES = 1000000;

   function automatic int bytes_per_op(input int n);
      return n / 8;
   endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// N-bit byte-granular shift register: parallel load, shift-in byte at the
// LSB end, shift-out toward the MSB end, and the MSB byte as an output.
module byte_shift_reg #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         shift_in,
   input  logic [7:0]   byte_in,
   input  logic         shift_out,
   output logic [N-1:0] q,
   output logic [7:0]   msb_byte
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         q <= '0;
      else if (load)      q <= load_val;
      else if (shift_in)  q <= {q[N-9:0], byte_in};
      else if (shift_out) q <= {q[N-9:0], 8'h00};
   end

   assign msb_byte = q[N-1 -: 8];

endmodule

// File: rtl/rsa_load_ctrl.sv
// Frames M, E, N from the rx byte stream, kicks the modexp core, and streams
// the result out MSB byte first. Optional inter-byte timeout: RSA_LOAD_TIMEOUT_EN.
module rsa_load_ctrl
   import rsa_ctrl_pkg::*;
#(
   parameter int N              = 16,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx_valid,
   input  logic [7:0]   rx_byte,
   output logic [N-1:0] op_m,
   output logic [N-1:0] op_e,
   output logic [N-1:0] op_n,
   output logic         core_start,
   input  logic         core_done,
   input  logic [N-1:0] core_result,
   output logic         tx_valid,
   output logic [7:0]   tx_byte,
   input  logic         tx_ready,
   output logic         busy,
   output logic         overrun,
   output logic         timeout
);

   localparam int CW = $clog2(bytes_per_op(N)) + 1;
   localparam logic [CW-1:0] LAST = CW'(bytes_per_op(N) - 1);

   load_state_t   state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          busy_q, overrun_q;
   logic          in_load, tmo_hit;
   logic [7:0]    unused_m_msb, unused_e_msb, unused_n_msb;
   logic [N-1:0]  unused_tx_q;

   assign in_load = (state == LOAD_M) || (state == LOAD_E) || (state == LOAD_N);

`ifdef RSA_LOAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          partial, timeout_q;

   // A frame is partial once any byte of it has been taken.
   assign partial = in_load && ((state != LOAD_M) || (cnt != '0));
   assign tmo_hit = partial && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt      <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit;
         if (!partial || rx_valid || tmo_hit) tcnt <= '0;
         else                                 tcnt <= tcnt + TW'(1);
      end
   end

   assign timeout = timeout_q;
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = 32'(TIMEOUT_CYCLES);
   assign tmo_hit    = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         LOAD_M, LOAD_E, LOAD_N: begin
            if (rx_valid) begin
               if (cnt == LAST) begin
                  cnt_d = '0;
                  case (state)
                     LOAD_M:  state_d = LOAD_E;
                     LOAD_E:  state_d = LOAD_N;
                     default: state_d = START;
                  endcase
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end
         START: state_d = WAIT;
         WAIT:  if (core_done) state_d = SEND;
         SEND: begin
            if (tx_ready) begin
               if (cnt == LAST) begin
                  cnt_d   = '0;
                  state_d = LOAD_M;
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end
         default: begin
            state_d = LOAD_M;
            cnt_d   = '0;
         end
      endcase
      if (tmo_hit) begin
         state_d = LOAD_M;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD_M;
         cnt       <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         busy_q    <= (state_d == START) || (state_d == WAIT) || (state_d == SEND);
         if (rx_valid && busy_q) overrun_q <= 1'b1;
      end
   end

   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign core_start = (state == START);
   assign tx_valid   = (state == SEND);

   byte_shift_reg #(.N(N)) u_op_m (
      .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
      .shift_in(rx_valid && (state == LOAD_M)), .byte_in(rx_byte),
      .shift_out(1'b0), .q(op_m), .msb_byte(unused_m_msb)
   );

   byte_shift_reg #(.N(N)) u_op_e (
      .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
      .shift_in(rx_valid && (state == LOAD_E)), .byte_in(rx_byte),
      .shift_out(1'b0), .q(op_e), .msb_byte(unused_e_msb)
   );

   byte_shift_reg #(.N(N)) u_op_n (
      .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
      .shift_in(rx_valid && (state == LOAD_N)), .byte_in(rx_byte),
      .shift_out(1'b0), .q(op_n), .msb_byte(unused_n_msb)
   );

   // Result register: captured once in WAIT, drained one byte per handshake.
   byte_shift_reg #(.N(N)) u_tx (
      .clk(clk), .rst_n(rst_n),
      .load((state == WAIT) && core_done), .load_val(core_result),
      .shift_in(1'b0), .byte_in(8'h00),
      .shift_out((state == SEND) && tx_ready),
      .q(unused_tx_q), .msb_byte(tx_byte)
   );

endmodule

// File: tb/tb_rsa_load_ctrl.sv
// Directed bench for rsa_load_ctrl with a frame-level reference model.
module tb_rsa_load_ctrl;
   localparam int N   = 16;
   localparam int BPO = N / 8;
   localparam int TMO = 8;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_byte = 8'h00;
   logic [N-1:0] op_m, op_e, op_n;
   logic         core_start, core_done = 1'b0;
   logic [N-1:0] core_result = '0;
   logic         tx_valid, tx_ready = 1'b1;
   logic [7:0]   tx_byte;
   logic         busy, overrun, timeout;

   int n_cmp = 0, n_bad = 0;
   bit checking = 1'b0;

   rsa_load_ctrl #(.N(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .op_m(op_m), .op_e(op_e), .op_n(op_n), .core_start(core_start),
      .core_done(core_done), .core_result(core_result), .tx_valid(tx_valid),
      .tx_byte(tx_byte), .tx_ready(tx_ready), .busy(busy), .overrun(overrun),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: bytes taken so far, phase of the transaction, and
   // the queue of result bytes still owed to the transmitter.
   int           fidx, phase, idle;
   logic [N-1:0] m_op [3];
   logic [7:0]   txq [$];
   bit           m_ovr, m_tmo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fidx = 0; phase = 0; idle = 0; m_ovr = 0; m_tmo = 0;
         for (int i = 0; i < 3; i++) m_op[i] = '0;
         txq.delete();
      end else begin
         m_tmo = 0;
         if (rx_valid && phase != 0) m_ovr = 1;
         case (phase)
            0: begin
               if (rx_valid) begin
                  m_op[fidx / BPO] = {m_op[fidx / BPO][N-9:0], rx_byte};
                  fidx++;
                  idle = 0;
                  if (fidx == 3 * BPO) begin fidx = 0; phase = 1; end
               end
`ifdef RSA_LOAD_TIMEOUT_EN
               else if (fidx != 0) begin
                  idle++;
                  if (idle == TMO) begin fidx = 0; idle = 0; m_tmo = 1; end
               end
`endif
            end
            1: phase = 2;
            2: if (core_done) begin
                  for (int i = 0; i < BPO; i++) txq.push_back(core_result[N-1-8*i -: 8]);
                  phase = 3;
               end
            default: if (tx_ready) begin
                  void'(txq.pop_front());
                  if (txq.size() == 0) phase = 0;
               end
         endcase
      end
   end

   logic [7:0] txlog [$];
   int         cs_cnt = 0, tmo_cnt = 0;

   always @(negedge clk) begin
      if (checking) begin
         chk("op_m", op_m, m_op[0]);
         chk("op_e", op_e, m_op[1]);
         chk("op_n", op_n, m_op[2]);
         chk("busy", busy, phase != 0);
         chk("core_start", core_start, phase == 1);
         chk("tx_valid", tx_valid, phase == 3);
         if (phase == 3 && txq.size() > 0) chk("tx_byte", tx_byte, txq[0]);
         chk("overrun", overrun, m_ovr);
         chk("timeout", timeout, m_tmo);
         if (tx_valid && tx_ready) txlog.push_back(tx_byte);
         if (core_start) cs_cnt++;
         if (timeout) tmo_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1; rx_byte = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
      send(b0); send(b1); send(b2); send(b3); send(b4); send(b5);
   endtask

   task automatic result(input logic [N-1:0] r);
      core_result = r; core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy && !tx_valid) begin ok = 1'b1; break; end
      end
      chk("idle_within_bound", ok, 1'b1);
      tick();
   endtask

   task automatic chk_log(input string nm);
      chk({nm, "_count"}, txlog.size(), 2);
      if (txlog.size() == 2) begin
         chk({nm, "_b0"}, txlog[0], 8'hBE);
         chk({nm, "_b1"}, txlog[1], 8'hEF);
      end
   endtask

   initial begin
      #13 rst_n = 1'b1;
      tick();
      chk("rst_op_m", op_m, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      checking = 1'b1;

      // Basic frame and back-to-back result
      frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
      @(negedge clk);
      chk("start_after_last", core_start, 1);
      chk("lit_op_m", op_m, 16'h1234);
      chk("lit_op_e", op_e, 16'h5678);
      chk("lit_op_n", op_n, 16'h9ABC);
      tick();
      chk("start_one_cycle", core_start, 0);
      chk("wait_busy", busy, 1);
      txlog.delete();
      result(16'hBEEF);
      wait_idle();
      chk_log("tx_seq");
      chk("start_pulses", cs_cnt, 1);
      chk("busy_after_send", busy, 0);

      // core_done outside WAIT is ignored; then stalled transmitter
      core_result = 16'h1111; core_done = 1'b1; tick(); core_done = 1'b0;
      chk("done_ignored", busy, 0);
      frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
      tick(); tick();
      tx_ready = 1'b0;
      txlog.delete();
      result(16'hBEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", tx_valid, 1);
         chk("stall_byte", tx_byte, 8'hBE);
         tick();
      end
      tx_ready = 1'b1;
      wait_idle();
      chk_log("stall_seq");

      // Overrun during WAIT
      frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
      tick(); tick();
      send(8'h55);
      @(negedge clk);
      chk("ovr_set", overrun, 1);
      chk("ovr_op_m", op_m, 16'h0102);
      chk("ovr_op_n", op_n, 16'h0506);
      tick();
      result(16'hCAFE);
      wait_idle();
      frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F);
      @(negedge clk);
      chk("next_op_m", op_m, 16'h0A0B);
      chk("next_op_n", op_n, 16'h0E0F);
      chk("ovr_sticky", overrun, 1);
      tick(); tick();
      result(16'h0001);
      wait_idle();

      // Asynchronous reset mid-frame
      send(8'hA1); send(8'hA2); send(8'hA3);
      checking = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_op_m", op_m, 0);
      chk("arst_op_e", op_e, 0);
      chk("arst_overrun", overrun, 0);
      chk("arst_busy", busy, 0);
      chk("arst_outs", {core_start, tx_valid, timeout}, 0);
      #5 rst_n = 1'b1;
      tick();
      checking = 1'b1;
      send(8'hAA); send(8'hBB);
      @(negedge clk);
      chk("post_rst_op_m", op_m, 16'hAABB);
      tick();

`ifdef RSA_LOAD_TIMEOUT_EN
      tmo_cnt = 0;
      send(8'h77);
      for (int i = 0; i < TMO + 3; i++) tick();
      chk("tmo_pulses", tmo_cnt, 1);
      send(8'hC1); send(8'hC2);
      @(negedge clk);
      chk("tmo_op_m", op_m, 16'hC1C2);
      chk("tmo_busy", busy, 0);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
